// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, 1-cycle imem issue/capture, small instruction FIFO, redirect flush.
// Optional FETCH_PERF_EN adds saturating fetch/stall performance counters.
module instruction_fetch_unit #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  output logic [ADDR_W-1:0] address_imem,
  output logic              fetch_req,
  input  logic [DATA_W-1:0] q_imem,
  output logic [DATA_W-1:0] insn_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              insn_valid,
  input  logic              insn_ready,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] last_insn_q, last_insn_d;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d;

  logic [DATA_W-1:0] insn_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

  logic              has_head;
  logic              pop;
  logic              capture;
  logic [CW:0]       occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    has_head     = (count_q != '0);
    insn_valid   = !ctrl_reset && has_head;
    pop          = insn_valid && insn_ready;
    capture      = inflight_q && !redirect_en && !ctrl_reset;
    // Credit counts buffered plus in-flight words, freeing the popped slot now.
    occ          = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    fetch_req    = !ctrl_reset && !redirect_en && (occ < DEPTH_C);
    address_imem = fetch_pc_q;

    insn_out = last_insn_q;
    pc_out   = last_pc_q;
    if (ctrl_reset) begin
      insn_out = '0;
      pc_out   = '0;
    end else if (has_head) begin
      insn_out = insn_mem_q[head_q];
      pc_out   = pc_mem_q[head_q];
    end

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    last_insn_d   = last_insn_q;
    last_pc_d     = last_pc_q;

    if (insn_valid) begin
      last_insn_d = insn_out;
      last_pc_d   = pc_out;
    end

    if (redirect_en) begin
      fetch_pc_d = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (fetch_req) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      if (capture) begin
        tail_d = ptr_inc(tail_q);
      end
      count_d = count_q + CW'(capture) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      last_insn_q   <= '0;
      last_pc_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      last_insn_q   <= last_insn_d;
      last_pc_q     <= last_pc_d;
    end
  end

  always_ff @(posedge clock) begin
    if (capture) begin
      insn_mem_q[tail_q] <= q_imem;
      pc_mem_q[tail_q]   <= inflight_pc_q;
    end
  end

  overflow_a: assert property (@(posedge clock) disable iff (ctrl_reset)
    !(capture && !pop && ({1'b0, count_q} == DEPTH_C)));

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (capture && (perf_fetch_q != '1)) begin
      perf_fetch_d = perf_fetch_q + 32'd1;
    end
    if (!insn_valid && !ctrl_reset && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a synchronous imem model
// and an expected-instruction scoreboard.
module tb_instruction_fetch_unit;

  logic        clock;
  logic        ctrl_reset;
  logic [11:0] address_imem;
  logic        fetch_req;
  logic [31:0] q_imem;
  logic [31:0] insn_out;
  logic [11:0] pc_out;
  logic        insn_valid;
  logic        insn_ready;
  logic        redirect_en;
  logic [11:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  typedef struct packed {
    logic [31:0] insn;
    logic [11:0] pc;
  } exp_t;

  exp_t sb[$];
  int   ncmp;
  int   nerr;

  instruction_fetch_unit #(
    .ADDR_W(12),
    .DATA_W(32),
    .DEPTH (2)
  ) dut (
    .clock       (clock),
    .ctrl_reset  (ctrl_reset),
    .address_imem(address_imem),
    .fetch_req   (fetch_req),
    .q_imem      (q_imem),
    .insn_out    (insn_out),
    .pc_out      (pc_out),
    .insn_valid  (insn_valid),
    .insn_ready  (insn_ready),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    q_imem <= 32'hA000_0000 | 32'(address_imem);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [11:0] p);
    exp_t e;
    e.pc   = p;
    e.insn = 32'hA000_0000 | 32'(p);
    sb.push_back(e);
  endtask

  task automatic smp();
    exp_t e;
    @(negedge clock);
    if (insn_valid && insn_ready) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
      end else begin
        e.pc   = 12'h000;
        e.insn = 32'hFFFF_FFFF;
      end
      chk("pop_pc", 32'(pc_out), 32'(e.pc));
      chk("pop_insn", insn_out, e.insn);
    end
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    ctrl_reset  = 1'b1;
    redirect_en = 1'b0;
    smp();
    chk("rst_valid", 32'(insn_valid), 32'd0);
    chk("rst_req", 32'(fetch_req), 32'd0);
    adv();
    smp();
    chk("rst_insn", insn_out, 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    adv();
    ctrl_reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    ncmp        = 0;
    nerr        = 0;
    ctrl_reset  = 1'b1;
    insn_ready  = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 12'h000;

    // Streaming with ready held high
    do_reset();
    insn_ready = 1'b1;
    for (int i = 0; i < 25; i++) push(12'(i));
    for (int c = 0; c < 22; c++) begin
      smp();
      chk("A_valid", 32'(insn_valid), 32'(c >= 2));
      if (c == 0) begin
        chk("A_req0", 32'(fetch_req), 32'd1);
        chk("A_addr0", 32'(address_imem), 32'd0);
        chk("A_pc0", 32'(pc_out), 32'd0);
      end
`ifdef FETCH_PERF_EN
      if (c == 10) begin
        chk("A_perf_fetch", perf_fetch_cnt, 32'd9);
        chk("A_perf_stall", perf_stall_cnt, 32'd2);
      end
`endif
      adv();
    end

    // Back-pressure fills the buffer, then drains in order
    do_reset();
    insn_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      smp();
      chk("B_valid", 32'(insn_valid), 32'(c >= 2));
      if (c >= 2) begin
        chk("B_req", 32'(fetch_req), 32'd0);
        chk("B_addr", 32'(address_imem), 32'd2);
      end
      adv();
    end
    insn_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(12'(i));
    for (int c = 0; c < 8; c++) begin
      smp();
      chk("B_flow", 32'(insn_valid), 32'd1);
      adv();
    end
    chk("B_drain", 32'(sb.size()), 32'd0);

    // Redirect while streaming
    do_reset();
    insn_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(12'(i));
    for (int c = 0; c < 7; c++) begin
      smp();
      adv();
    end
    redirect_en = 1'b1;
    redirect_pc = 12'h040;
    smp();
    chk("C_pc5", 32'(pc_out), 32'd5);
    chk("C_req_redir", 32'(fetch_req), 32'd0);
    adv();
    redirect_en = 1'b0;
    for (int i = 0; i < 4; i++) push(12'h040 + 12'(i));
    smp();
    chk("C_gap1", 32'(insn_valid), 32'd0);
    chk("C_req1", 32'(fetch_req), 32'd1);
    chk("C_addr1", 32'(address_imem), 32'h040);
    adv();
    smp();
    chk("C_gap2", 32'(insn_valid), 32'd0);
    adv();
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("C_flow", 32'(insn_valid), 32'd1);
      adv();
    end
    chk("C_drain", 32'(sb.size()), 32'd0);

    // Redirect near the top of the address space wraps to zero
    push(12'h044);
    redirect_en = 1'b1;
    redirect_pc = 12'hFFE;
    smp();
    adv();
    redirect_en = 1'b0;
    push(12'hFFE);
    push(12'hFFF);
    push(12'h000);
    push(12'h001);
    for (int k = 0; k < 6; k++) begin
      smp();
      chk("D_valid", 32'(insn_valid), 32'(k >= 2));
      adv();
    end
    chk("D_drain", 32'(sb.size()), 32'd0);

    // Reset while the buffer is full
    do_reset();
    insn_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      smp();
      if (c == 4) begin
        chk("E_full_valid", 32'(insn_valid), 32'd1);
        chk("E_full_req", 32'(fetch_req), 32'd0);
      end
      adv();
    end
    ctrl_reset = 1'b1;
    smp();
    chk("E_rst_valid", 32'(insn_valid), 32'd0);
    adv();
    ctrl_reset = 1'b0;
    insn_ready = 1'b1;
    push(12'h000);
    push(12'h001);
    push(12'h002);
    smp();
    chk("E_valid0", 32'(insn_valid), 32'd0);
    chk("E_pc0", 32'(pc_out), 32'd0);
    chk("E_insn0", insn_out, 32'd0);
    adv();
    for (int c = 1; c < 5; c++) begin
      smp();
      chk("E_valid", 32'(insn_valid), 32'(c >= 2));
      adv();
    end
    chk("E_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
